ad9833_spi_rx: RTL and testbench
================================

// Module: ad9833_spi_rx
// PURPOSE
// - Receive side of the AD9833 3-wire serial link (fsync/sclk/sdata): oversamples the pins on the
//   system clock, deframes 16-bit MSB-first words and decodes them into a shadow copy of the DDS
//   register file (CONTROL, FREQ0/1, PHASE0/1).
// - Sits on the far end of the ad9833 transmit path: loopback checker in the FPGA and bench monitor.
// PARAMETERS
// - SYNC_STAGES  2  synchroniser depth on fsync/sclk/sdata (legal 2..4)
// - ERR_CNT_W    8  width of the saturating error counter
// PORTS
// - clock        in   1   system clock
// - reset        in   1   asynchronous, active-high reset
// - fsync        in   1   frame sync, active low (async to clock)
// - sclk         in   1   serial clock, data sampled on its falling edge (async)
// - sdata        in   1   serial data, MSB first (async)
// - word_valid   out  1   1-cycle pulse: complete 16-bit word received
// - word_data    out  16  last received word, valid with word_valid and held after
// - ctrl         out  14  CONTROL bits D13..D0
// - freq0        out  28  FREQ0 shadow
// - freq1        out  28  FREQ1 shadow
// - phase0       out  12  PHASE0 shadow
// - phase1       out  12  PHASE1 shadow
// - frame_err    out  1   1-cycle pulse: fsync rose with 1..15 bits shifted
// - seq_err      out  1   1-cycle pulse: B28 pair broken (see below)
// - err_count    out  ERR_CNT_W  saturating count of frame_err+seq_err events
// BEHAVIOUR
// - Reset: every output and internal register 0; bit counter 0; B28 pending flag clear.
// - Inputs pass SYNC_STAGES flops; sclk falling edge = prev sync 1, current sync 0.
// - Bit capture: on a falling edge while synced fsync=0, shift synced sdata into shift reg, cnt++.
// - cnt==15 at capture: word complete, cnt wraps to 0; fsync may stay low for back-to-back words.
// - fsync synced 0->1 with cnt!=0: frame_err, cnt<=0, partial word discarded. cnt==0: no error.
// - Falling edges while fsync high ignored. Input timing: sclk high and low each >= 3 clock periods.
// - Latency: word_valid and all shadow updates occur in the same cycle, SYNC_STAGES+1 clocks after
//   the 16th sclk falling edge at the pin.
// - Decode on word complete, by D15:D14:
//   00 CONTROL: ctrl<=D13:D0; clears B28 pending (no error).
//   01/10 FREQ0/FREQ1 (14-bit payload P):
//     B28=ctrl[13]=1: no pending -> hold P as LSB, latch target, set pending.
//       pending, same target -> target<={P,lsb}, clear pending.
//       pending, other target -> seq_err; held LSB dropped; P becomes new LSB for new target.
//     B28=0: HLB=ctrl[12]=1 -> target[27:14]<=P; else target[13:0]<=P; other half kept.
//   11 PHASE: D13=0 -> phase0<=D11:D0, D13=1 -> phase1<=D11:D0; D12 ignored; pending unaffected.
// - ctrl[8] (RESET) and sleep bits are recorded only; they do not clear shadows.
// - frame_err and word-complete cannot coincide (fsync rise requires cnt!=0 vs wrap to 0).
// - err_count: +1 per cycle with frame_err or seq_err (+1 if both); saturates at all-ones.
// - Reset asserted mid-word: partial word lost, state as after reset, no error pulse.
// CONFIGURATION
// - AD9833_RX_AVALON_EN defined: adds Avalon-MM read slave ports
//   address in 3, read in 1, readdata out 32 (read latency 1, zero-extended, no waitrequest):
//   0 word_data, 1 ctrl, 2 freq0, 3 freq1, 4 phase0, 5 phase1, 6 err_count, 7 {pending,cnt[3:0]}.
//   Read of addr 6 in the cycle after read clears err_count (increment same cycle wins, count=1).
// - Not defined: ports absent, err_count never cleared except by reset; decode identical.
// TESTING
// - ctrl word 0x2000 then FREQ0 0x4000|0x1234, 0x4000|0x0ABC -> freq0=0x2AF1234, one word_valid each.
// - ctrl 0x1000 (B28=0,HLB=1), FREQ1 0x8000|0x3FFF -> freq1[27:14]=0x3FFF, freq1[13:0] unchanged.
// - PHASE words 0xC123 and 0xE456 in one fsync-low burst -> phase0=0x123, phase1=0x456, 2 pulses.
// - fsync rises after 7 bits -> frame_err once, err_count=1, no word_valid, next full word decodes.
// - B28=1: FREQ0 LSB then FREQ1 word -> seq_err, freq0 unchanged; then FREQ1 MSB completes freq1.
// - Reset pulsed after 10 bits -> all outputs 0; following full word 0x2000 -> ctrl=0x2000.

Source files
------------

// File: rtl/ad9833_spi_rx.sv
// ad9833_spi_rx -- receive side of the AD9833 3-wire serial link.
// Oversamples fsync/sclk/sdata on the system clock, deframes 16-bit MSB-first
// words on sclk falling edges and decodes them into a shadow copy of the DDS
// register file (CONTROL, FREQ0/1, PHASE0/1). Framing and B28 sequencing
// faults raise one-cycle pulses and bump a saturating error counter.
// Optional build macro AD9833_RX_AVALON_EN adds an Avalon-MM read slave
// (read latency 1) that exposes the shadows and clears err_count on read.

module ad9833_spi_rx #(
    parameter int SYNC_STAGES = 2,   // synchroniser depth, legal 2..4
    parameter int ERR_CNT_W   = 8    // saturating error counter width
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef AD9833_RX_AVALON_EN
    input  logic [2:0]           address,
    input  logic                 read,
    output logic [31:0]          readdata,
`endif
    input  logic                 fsync,
    input  logic                 sclk,
    input  logic                 sdata,
    output logic                 word_valid,
    output logic [15:0]          word_data,
    output logic [13:0]          ctrl,
    output logic [27:0]          freq0,
    output logic [27:0]          freq1,
    output logic [11:0]          phase0,
    output logic [11:0]          phase1,
    output logic                 frame_err,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Command field D15:D14 of a received word.
    typedef enum logic [1:0] {
        CMD_CTRL  = 2'b00,
        CMD_FREQ0 = 2'b01,
        CMD_FREQ1 = 2'b10,
        CMD_PHASE = 2'b11
    } cmd_e;

    // Synchronisers and edge-detect history.
    logic [SYNC_STAGES-1:0] fsync_sync_q, sclk_sync_q, sdata_sync_q;
    logic                   sclk_prev_q, fsync_prev_q;

    // Deframer state.
    logic [14:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;

    // Decoded shadows and B28 pairing state (pend_tgt: 0 = FREQ0, 1 = FREQ1).
    logic                 word_valid_q, word_valid_d;
    logic [15:0]          word_data_q, word_data_d;
    logic [13:0]          ctrl_q, ctrl_d;
    logic [27:0]          freq0_q, freq0_d, freq1_q, freq1_d;
    logic [11:0]          phase0_q, phase0_d, phase1_q, phase1_d;
    logic                 pending_q, pending_d;
    logic                 pend_tgt_q, pend_tgt_d;
    logic [13:0]          lsb_q, lsb_d;
    logic                 frame_err_q, frame_err_d;
    logic                 seq_err_q, seq_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

`ifdef AD9833_RX_AVALON_EN
    logic [31:0] readdata_q, readdata_d;
    logic        clr_q, clr_d;
`endif

    // Combinational views of the synchronised pins and the word being completed.
    logic        fsync_s, sclk_s, sdata_s;
    logic        sclk_fall, fsync_rise, capture;
    logic [15:0] word;
    cmd_e        cmd;
    logic        freq_sel;
    logic [13:0] payload;
    logic [27:0] freq_cur, freq_new;
    logic        freq_wr, err_event;

    assign fsync_s    = fsync_sync_q[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s    = sdata_sync_q[SYNC_STAGES-1];
    assign sclk_fall  = sclk_prev_q & ~sclk_s;
    assign fsync_rise = ~fsync_prev_q & fsync_s;
    assign capture    = sclk_fall & ~fsync_s;
    assign word       = {shift_q, sdata_s};
    assign cmd        = cmd_e'(word[15:14]);
    assign freq_sel   = word[15];
    assign payload    = word[13:0];

    // Next-state: bit capture, framing check, word decode and error counting.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        word_valid_d = 1'b0;
        word_data_d  = word_data_q;
        ctrl_d       = ctrl_q;
        freq0_d      = freq0_q;
        freq1_d      = freq1_q;
        phase0_d     = phase0_q;
        phase1_d     = phase1_q;
        pending_d    = pending_q;
        pend_tgt_d   = pend_tgt_q;
        lsb_d        = lsb_q;
        frame_err_d  = 1'b0;
        seq_err_d    = 1'b0;
        err_count_d  = err_count_q;
        freq_cur     = freq_sel ? freq1_q : freq0_q;
        freq_new     = freq_cur;
        freq_wr      = 1'b0;

        if (capture) begin
            shift_d = word[14:0];
            cnt_d   = cnt_q + 4'd1;   // 15 wraps to 0: back-to-back words need no fsync toggle
            if (cnt_q == 4'd15) begin
                word_valid_d = 1'b1;
                word_data_d  = word;
                unique case (cmd)
                    CMD_CTRL: begin
                        ctrl_d    = payload;
                        pending_d = 1'b0;
                    end
                    CMD_FREQ0, CMD_FREQ1: begin
                        if (ctrl_q[13]) begin
                            // B28 mode: LSB half first, then MSB half to the same register.
                            if (!pending_q) begin
                                lsb_d      = payload;
                                pend_tgt_d = freq_sel;
                                pending_d  = 1'b1;
                            end else if (pend_tgt_q == freq_sel) begin
                                freq_new  = {payload, lsb_q};
                                freq_wr   = 1'b1;
                                pending_d = 1'b0;
                            end else begin
                                // Pair broken: drop held LSB, restart pairing on the new target.
                                seq_err_d  = 1'b1;
                                lsb_d      = payload;
                                pend_tgt_d = freq_sel;
                            end
                        end else begin
                            freq_wr  = 1'b1;
                            freq_new = ctrl_q[12] ? {payload, freq_cur[13:0]}
                                                  : {freq_cur[27:14], payload};
                        end
                    end
                    CMD_PHASE: begin
                        if (word[13]) phase1_d = word[11:0];
                        else          phase0_d = word[11:0];
                    end
                endcase
            end
        end else if (fsync_rise && cnt_q != 4'd0) begin
            frame_err_d = 1'b1;
            cnt_d       = 4'd0;
        end

        if (freq_wr) begin
            if (freq_sel) freq1_d = freq_new;
            else          freq0_d = freq_new;
        end

        err_event = frame_err_d | seq_err_d;
`ifdef AD9833_RX_AVALON_EN
        if (clr_q) begin
            err_count_d = err_event ? ERR_CNT_W'(1) : '0;
        end else
`endif
        if (err_event && !(&err_count_q)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

`ifdef AD9833_RX_AVALON_EN
    // Avalon read mux, registered for one cycle of read latency.
    always_comb begin
        readdata_d = readdata_q;
        clr_d      = read && (address == 3'd6);
        if (read) begin
            unique case (address)
                3'd0: readdata_d = 32'(word_data_q);
                3'd1: readdata_d = 32'(ctrl_q);
                3'd2: readdata_d = 32'(freq0_q);
                3'd3: readdata_d = 32'(freq1_q);
                3'd4: readdata_d = 32'(phase0_q);
                3'd5: readdata_d = 32'(phase1_q);
                3'd6: readdata_d = 32'(err_count_q);
                3'd7: readdata_d = 32'({pending_q, cnt_q});
            endcase
        end
    end
`endif

    // State registers; everything clears on asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsync_sync_q <= '0;
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            sclk_prev_q  <= 1'b0;
            fsync_prev_q <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            ctrl_q       <= '0;
            freq0_q      <= '0;
            freq1_q      <= '0;
            phase0_q     <= '0;
            phase1_q     <= '0;
            pending_q    <= 1'b0;
            pend_tgt_q   <= 1'b0;
            lsb_q        <= '0;
            frame_err_q  <= 1'b0;
            seq_err_q    <= 1'b0;
            err_count_q  <= '0;
`ifdef AD9833_RX_AVALON_EN
            readdata_q   <= '0;
            clr_q        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, as real flops do.
            fsync_sync_q <= {fsync_sync_q[SYNC_STAGES-2:0], fsync};
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
            sclk_prev_q  <= sclk_s;
            fsync_prev_q <= fsync_s;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            ctrl_q       <= ctrl_d;
            freq0_q      <= freq0_d;
            freq1_q      <= freq1_d;
            phase0_q     <= phase0_d;
            phase1_q     <= phase1_d;
            pending_q    <= pending_d;
            pend_tgt_q   <= pend_tgt_d;
            lsb_q        <= lsb_d;
            frame_err_q  <= frame_err_d;
            seq_err_q    <= seq_err_d;
            err_count_q  <= err_count_d;
`ifdef AD9833_RX_AVALON_EN
            readdata_q   <= readdata_d;
            clr_q        <= clr_d;
`endif
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign ctrl       = ctrl_q;
    assign freq0      = freq0_q;
    assign freq1      = freq1_q;
    assign phase0     = phase0_q;
    assign phase1     = phase1_q;
    assign frame_err  = frame_err_q;
    assign seq_err    = seq_err_q;
    assign err_count  = err_count_q;
`ifdef AD9833_RX_AVALON_EN
    assign readdata   = readdata_q;
`endif

endmodule

// File: tb/tb_ad9833_spi_rx.sv
// tb_ad9833_spi_rx -- self-checking bench for ad9833_spi_rx (default build).
// Drives the serial pins from tasks, keeps a word-level model of the AD9833
// register file and compares every shadow, pulse count and err_count after
// each frame; directed scenarios first, then randomized frames.

module tb_ad9833_spi_rx;

    localparam int SYNC_STAGES = 2;
    localparam int ERR_CNT_W   = 8;
    localparam int HALF        = 4;   // clocks per sclk phase

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 fsync, sclk, sdata;
    logic                 word_valid;
    logic [15:0]          word_data;
    logic [13:0]          ctrl;
    logic [27:0]          freq0, freq1;
    logic [11:0]          phase0, phase1;
    logic                 frame_err, seq_err;
    logic [ERR_CNT_W-1:0] err_count;

    ad9833_spi_rx #(.SYNC_STAGES(SYNC_STAGES), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .fsync      (fsync),
        .sclk       (sclk),
        .sdata      (sdata),
        .word_valid (word_valid),
        .word_data  (word_data),
        .ctrl       (ctrl),
        .freq0      (freq0),
        .freq1      (freq1),
        .phase0     (phase0),
        .phase1     (phase1),
        .frame_err  (frame_err),
        .seq_err    (seq_err),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int fall_cyc;
    int wv_cnt = 0, fe_cnt = 0, se_cnt = 0, wv_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling clock edge.
    always @(negedge clock) begin
        if (word_valid) begin
            wv_cnt = wv_cnt + 1;
            wv_cyc = cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (seq_err)   se_cnt = se_cnt + 1;
    end

    // Reference model of the register file, updated once per delivered word.
    logic [13:0] m_ctrl;
    logic [27:0] m_freq [2];
    logic [11:0] m_phase [2];
    logic        m_pend, m_tgt;
    logic [13:0] m_lsb;
    logic [15:0] m_last;
    int          m_err, m_wv = 0, m_fe = 0, m_se = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_freq[0] = '0; m_freq[1] = '0; m_phase[0] = '0; m_phase[1] = '0;
        m_pend = 1'b0; m_tgt = 1'b0; m_lsb = '0; m_last = '0; m_err = 0;
    endtask

    task automatic model_err();
        if (m_err < (1 << ERR_CNT_W) - 1) m_err++;
    endtask

    task automatic model_word(input logic [15:0] w);
        int t;
        m_wv++;
        m_last = w;
        case (w[15:14])
            2'b00: begin m_ctrl = w[13:0]; m_pend = 1'b0; end
            2'b11: if (w[13]) m_phase[1] = w[11:0]; else m_phase[0] = w[11:0];
            default: begin
                t = (w[15:14] == 2'b10) ? 1 : 0;
                if (m_ctrl[13]) begin
                    if (!m_pend) begin
                        m_lsb = w[13:0]; m_tgt = t[0]; m_pend = 1'b1;
                    end else if (m_tgt == t[0]) begin
                        m_freq[t] = {w[13:0], m_lsb}; m_pend = 1'b0;
                    end else begin
                        m_se++; model_err(); m_lsb = w[13:0]; m_tgt = t[0];
                    end
                end else if (m_ctrl[12]) begin
                    m_freq[t][27:14] = w[13:0];
                end else begin
                    m_freq[t][13:0] = w[13:0];
                end
            end
        endcase
    endtask

    // Shift the top n bits of w out MSB first; data changes while sclk is high.
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            sclk  = 1'b1;
            sdata = w[15-i];
            tick(HALF);
            sclk     = 1'b0;
            fall_cyc = cyc;
            tick(HALF);
        end
        sclk = 1'b1;
    endtask

    // One fsync-low frame: n full words, then `extra` stray bits (forces a frame error).
    task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                              input int n, input int extra);
        logic [15:0] ws [3];
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        fsync = 1'b0;
        tick(HALF);
        for (int i = 0; i < n; i++) begin
            send_bits(ws[i], 16);
            model_word(ws[i]);
        end
        if (extra > 0) begin
            send_bits(16'($urandom), extra);
            m_fe++;
            model_err();
        end
        tick(HALF);
        fsync = 1'b1;
        tick(SYNC_STAGES + 4);
    endtask

    task automatic check_all(input string tag);
        check({tag, "/word_valid_count"}, wv_cnt, m_wv);
        check({tag, "/frame_err_count"}, fe_cnt, m_fe);
        check({tag, "/seq_err_count"}, se_cnt, m_se);
        check({tag, "/ctrl"}, ctrl, m_ctrl);
        check({tag, "/freq0"}, freq0, m_freq[0]);
        check({tag, "/freq1"}, freq1, m_freq[1]);
        check({tag, "/phase0"}, phase0, m_phase[0]);
        check({tag, "/phase1"}, phase1, m_phase[1]);
        check({tag, "/word_data"}, word_data, m_last);
        check({tag, "/err_count"}, err_count, m_err);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/word_valid"}, word_valid, 0);
        check({tag, "/word_data"}, word_data, 0);
        check({tag, "/ctrl"}, ctrl, 0);
        check({tag, "/freq0"}, freq0, 0);
        check({tag, "/freq1"}, freq1, 0);
        check({tag, "/phase0"}, phase0, 0);
        check({tag, "/phase1"}, phase1, 0);
        check({tag, "/frame_err"}, frame_err, 0);
        check({tag, "/seq_err"}, seq_err, 0);
        check({tag, "/err_count"}, err_count, 0);
    endtask

    function automatic logic [15:0] rand_word();
        logic [1:0]  kind;
        logic [13:0] p;
        kind = 2'($urandom_range(0, 3));
        p    = 14'($urandom);
        return {kind, p};
    endfunction

    initial begin
        int          wv0, fe0, n, extra;
        logic [27:0] f0_keep;

        reset = 1'b1; fsync = 1'b1; sclk = 1'b1; sdata = 1'b0;
        model_reset();
        tick(3);
        check_zero("reset");
        reset = 1'b0;
        tick(SYNC_STAGES + 3);
        check_all("post_reset");

        // B28 two-word load of FREQ0, plus latency from 16th falling sclk edge.
        send_frame(16'h2000, 0, 0, 1, 0);
        check("latency", wv_cyc - fall_cyc, SYNC_STAGES + 1);
        check("ctrl_b28", ctrl, 14'h2000);
        send_frame(16'h4000 | 16'h1234, 0, 0, 1, 0);
        check("freq0_lsb_only", freq0, 0);
        send_frame(16'h4000 | 16'h0ABC, 0, 0, 1, 0);
        check("freq0_b28", freq0, 28'h2AF1234);
        check_all("b28_load");

        // B28=0, HLB=1: only the upper half of FREQ1 changes.
        send_frame(16'h1000, 16'hBFFF, 0, 2, 0);
        check("freq1_hlb", freq1, 28'hFFFC000);
        check_all("hlb_load");

        // Two PHASE words back to back under one fsync-low.
        wv0 = wv_cnt;
        send_frame(16'hC123, 16'hE456, 0, 2, 0);
        check("phase0", phase0, 12'h123);
        check("phase1", phase1, 12'h456);
        check("phase_pulses", wv_cnt - wv0, 2);
        check_all("phase_burst");

        // Truncated frame of 7 bits, then a normal word.
        wv0 = wv_cnt;
        send_frame(0, 0, 0, 0, 7);
        check("partial_no_word", wv_cnt - wv0, 0);
        check("partial_err_count", err_count, 1);
        check_all("partial");
        send_frame(16'h4001, 0, 0, 1, 0);
        check_all("after_partial");

        // Broken B28 pair: FREQ0 LSB then FREQ1 word, then FREQ1 MSB completes.
        send_frame(16'h2000, 16'h4111, 0, 2, 0);
        f0_keep = freq0;
        send_frame(16'h8222, 0, 0, 1, 0);
        check("seq_err_count", se_cnt, 1);
        check("seq_freq0_kept", freq0, f0_keep);
        send_frame(16'h8333, 0, 0, 1, 0);
        check("seq_freq1", freq1, 28'h0CCC222);
        check("seq_err_total", err_count, 2);
        check_all("seq_break");

        // Reset mid-word: no error pulse, everything back to zero.
        fe0 = fe_cnt;
        fsync = 1'b0;
        tick(HALF);
        send_bits(16'hFFFF, 10);
        reset = 1'b1;
        tick(2);
        model_reset();
        check_zero("mid_reset");
        fsync = 1'b1;
        reset = 1'b0;
        tick(SYNC_STAGES + 4);
        check("mid_reset_no_fe", fe_cnt - fe0, 0);
        check_all("mid_reset_after");
        send_frame(16'h2000, 0, 0, 1, 0);
        check("reset_then_ctrl", ctrl, 14'h2000);
        check_all("reset_then_word");

        // Randomized frames: 0..3 words, sometimes followed by stray bits.
        for (int it = 0; it < 40; it++) begin
            n     = $urandom_range(0, 3);
            extra = ($urandom_range(0, 3) == 0 || n == 0) ? $urandom_range(1, 15) : 0;
            send_frame(rand_word(), rand_word(), rand_word(), n, extra);
            check_all($sformatf("rand%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
